// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer: owns the A/B term registers and adder, and emits one term per
// valid/ready handshake. It pulses done at the end of a run and flags emitted wrap-around.
module fib_seq_ctrl #(
  parameter int SIZE  = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             ready_in,
  output logic [SIZE-1:0]  term_out,
  output logic             term_valid,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [1:0]       sel
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_t;

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_ONE  = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b11;

  state_t           r_state;
  logic [SIZE-1:0]  r_a;
  logic [SIZE-1:0]  r_b;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_n;
  logic             r_ovf_a;
  logic             r_ovf_b;
  logic             r_overflow;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic [SIZE-1:0]  w_sum;
  logic             w_carry;
  logic             w_accept;
  logic             w_last;
  logic [1:0]       w_sel;

  assign {w_carry, w_sum} = {1'b0, r_a} + {1'b0, r_b};
  assign w_accept = (r_state == S_EMIT) && r_valid && ready_in;
  assign w_last   = (r_idx == r_n - CNT_W'(1));

  // NOTE: every output of always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_sel = SEL_HOLD;
    case (r_state)
      S_IDLE: if (start && (n_terms != '0)) w_sel = SEL_ONE;
      S_EMIT: if (w_accept && !w_last)      w_sel = SEL_SUM;
      default: w_sel = SEL_HOLD;
    endcase
  end

  // Term datapath is steered purely by the select, so sel is exactly what loads B.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else begin
      case (w_sel)
        SEL_ONE: begin
          r_a <= '0;
          r_b <= SIZE'(1);
        end
        SEL_SUM: begin
          r_a <= r_b;
          r_b <= w_sum;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_n        <= '0;
      r_ovf_a    <= 1'b0;
      r_ovf_b    <= 1'b0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_overflow <= 1'b0;
            r_busy     <= 1'b1;
            if (n_terms != '0) begin
              r_n     <= n_terms;
              r_idx   <= '0;
              r_ovf_a <= 1'b0;
              r_ovf_b <= 1'b0;
              r_valid <= 1'b1;
              r_state <= S_EMIT;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_EMIT: begin
          if (w_accept) begin
            if (r_ovf_a) r_overflow <= 1'b1;
            if (w_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + CNT_W'(1);
              // Carry follows the term it belongs to, so wrap is flagged only once emitted.
              r_ovf_a <= r_ovf_b;
              r_ovf_b <= r_ovf_b | w_carry;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign term_out   = r_a;
  assign term_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign overflow   = r_overflow;
  assign sel        = w_sel;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Self-checking bench for fib_seq_ctrl: directed plus randomized runs with random backpressure,
// compared against a plain-arithmetic Fibonacci reference model.
module tb_fib_seq_ctrl;

  localparam int SIZE  = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic             ready_in;
  logic [SIZE-1:0]  term_out;
  logic             term_valid;
  logic             busy;
  logic             done;
  logic             overflow;
  logic [1:0]       sel;

  int n_checks = 0;
  int n_errors = 0;

  fib_seq_ctrl #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_terms    (n_terms),
    .ready_in   (ready_in),
    .term_out   (term_out),
    .term_valid (term_valid),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .sel        (sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: true (unbounded) Fibonacci value of term k.
  function automatic longint unsigned fib(input int k);
    longint unsigned f0 = 0;
    longint unsigned f1 = 1;
    longint unsigned t;
    for (int i = 0; i < k; i++) begin
      t  = f0 + f1;
      f0 = f1;
      f1 = t;
    end
    return f0;
  endfunction

  function automatic logic [31:0] exp_term(input int k);
    return 32'(fib(k) % (64'd1 << SIZE));
  endfunction

  function automatic bit exp_wrap(input int k);
    return fib(k) >= (64'd1 << SIZE);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_term"},  term_out,   0);
    check({tag, "_valid"}, term_valid, 0);
    check({tag, "_busy"},  busy,       0);
    check({tag, "_done"},  done,       0);
    check({tag, "_sel"},   sel,        0);
  endtask

  // mode 0: ready always 1; mode 1: random ready; mode 2: stall 3 cycles while term_out==2.
  task automatic run(input int n, input int mode, input bit inject_start);
    int  k      = 0;
    int  stalls = 0;
    bit  ovf    = 1'b0;
    bit  seen   = 1'b0;
    bit  rdy;
    @(negedge clk);
    start    = 1'b1;
    n_terms  = CNT_W'(n);
    ready_in = 1'($urandom);
    #1 check("sel_start", sel, (n != 0) ? 2'b01 : 2'b00);
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      @(negedge clk);
      start   = inject_start && ($urandom_range(0, 3) == 0);
      n_terms = CNT_W'($urandom);
      if (done) begin
        seen  = 1'b1;
        start = 1'b0;
        check("done_count", k, n);
        check("done_valid", term_valid, 0);
        check("done_busy",  busy, 1);
        check("done_ovf",   overflow, ovf);
      end else begin
        check("emit_valid", term_valid, 1);
        check("emit_busy",  busy, 1);
        check("emit_term",  term_out, exp_term(k));
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = ($urandom_range(0, 2) != 0);
          default: rdy = !((term_out == SIZE'(2)) && (stalls < 3));
        endcase
        if (!rdy) stalls++;
        ready_in = rdy;
        #1 check("emit_sel", sel, !rdy ? 2'b00 : ((k == n - 1) ? 2'b00 : 2'b11));
        if (rdy) begin
          if (exp_wrap(k)) ovf = 1'b1;
          k++;
        end
      end
    end
    if (!seen) check("done_timeout", 0, 1);
    if (mode == 2) check("bp_stalls", stalls, 3);
    @(negedge clk);
    start = 1'b0;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_valid", term_valid, 0);
    check("post_ovf", overflow, ovf);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    n_terms  = '0;
    ready_in = 1'b0;
    #12;
    check_idle_outputs("reset");
    check("reset_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_idle_outputs("post_reset");
    end

    run(8, 0, 1'b0);
    run(9, 0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("ovf_held", overflow, 1);
    end
    run(6, 2, 1'b0);
    run(0, 0, 1'b0);
    run(7, 0, 1'b1);

    // Asynchronous reset mid-run, after three terms accepted.
    @(negedge clk);
    start    = 1'b1;
    n_terms  = CNT_W'(10);
    ready_in = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 check("pre_reset_term", term_out, 2);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_done_after_reset", done, 0);
      check("no_valid_after_reset", term_valid, 0);
    end
    run(3, 0, 1'b0);

    for (int i = 0; i < 20; i++) run($urandom_range(0, 15), 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
